// File: rtl/zxbus_xactor.sv
// zxbus_xactor: single-outstanding ZX Spectrum bus cycle generator.
//
// Turns one command (read/write, IORQ/MREQ, address, write data) into a
// timed ZX bus cycle: SETUP (address/data valid), STROBE (IORQ_n or MREQ_n
// together with RD_n or WR_n low), optional WAIT, HOLD, then a one-cycle
// completion pulse in DONE.
//
// Optional build macro: ZXBUS_WAIT_EN
//   defined   -> zxgenwait_n extends STROBE through a WAIT state, with a
//                WAIT_MAX cycle timeout that forces completion with
//                rsp_timeout=1 and rsp_rdata=8'hFF.
//   undefined -> zxgenwait_n is ignored, latency is fixed, rsp_timeout=0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake; cmd_wr, cmd_io, cmd_addr,
//                       cmd_wdata are captured on the accepting edge
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           read data (8'hFF for writes and timeouts)
//   rsp_timeout         last completion ended by timeout
//   zxa, zxid_o,        ZX address, data out and its drive enable
//   zxid_oe, zxid_i     ZX data in
//   zxiorq_n, zxmreq_n, active-low ZX strobes
//   zxrd_n, zxwr_n
//   zxgenwait_n         active-low wait request from the device
//   busy                FSM not in IDLE
//   dbg_state           current FSM state encoding
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE and never during reset;
// cmd_valid may drop at any time without effect while cmd_ready is 0.
module zxbus_xactor #(
  parameter int AW       = 16,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic          cmd_io,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_wdata,
  output logic          rsp_valid,
  output logic [7:0]    rsp_rdata,
  output logic          rsp_timeout,
  output logic [AW-1:0] zxa,
  output logic [7:0]    zxid_o,
  output logic          zxid_oe,
  input  logic [7:0]    zxid_i,
  output logic          zxiorq_n,
  output logic          zxmreq_n,
  output logic          zxrd_n,
  output logic          zxwr_n,
  input  logic          zxgenwait_n,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD, S_DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q, io_q;
  logic [AW-1:0] zxa_q;
  logic [7:0]    zxid_o_q;
  logic          zxid_oe_q;
  logic          iorq_n_q, mreq_n_q, rd_n_q, wr_n_q;
  logic [7:0]    rdata_cap_q;
  logic          to_cap_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_rdata_q;
  logic          rsp_timeout_q;
  logic          exit_ok, exit_to;

`ifdef ZXBUS_WAIT_EN
  logic [7:0]    wcnt_q;
`else
  logic          unused_gw;
  assign unused_gw = zxgenwait_n;
`endif

  // Strobe release decision: exit_ok is a normal end of the strobe phase
  // (read data sampled this cycle), exit_to is a wait timeout.
  always_comb begin
    exit_ok = 1'b0;
    exit_to = 1'b0;
    if (state_q == S_STROBE && cnt_q == 4'(T_STROBE - 1)) begin
`ifdef ZXBUS_WAIT_EN
      exit_ok = zxgenwait_n;
`else
      exit_ok = 1'b1;
`endif
    end
`ifdef ZXBUS_WAIT_EN
    if (state_q == S_WAIT) begin
      if (zxgenwait_n)                       exit_ok = 1'b1;
      else if (wcnt_q == 8'(WAIT_MAX - 1))   exit_to = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      io_q          <= 1'b0;
      zxa_q         <= '0;
      zxid_o_q      <= '0;
      zxid_oe_q     <= 1'b0;
      iorq_n_q      <= 1'b1;
      mreq_n_q      <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      rdata_cap_q   <= 8'hFF;
      to_cap_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'hFF;
      rsp_timeout_q <= 1'b0;
`ifdef ZXBUS_WAIT_EN
      wcnt_q        <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_q  <= S_SETUP;
            cnt_q    <= '0;
            wr_q     <= cmd_wr;
            io_q     <= cmd_io;
            zxa_q    <= cmd_addr;
            to_cap_q <= 1'b0;
            if (cmd_wr) begin
              zxid_o_q  <= cmd_wdata;
              zxid_oe_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'(T_SETUP - 1)) begin
            state_q  <= S_STROBE;
            cnt_q    <= '0;
            iorq_n_q <= ~io_q;
            mreq_n_q <= io_q;
            rd_n_q   <= wr_q;
            wr_n_q   <= ~wr_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_STROBE: begin
          if (cnt_q == 4'(T_STROBE - 1)) begin
`ifdef ZXBUS_WAIT_EN
            if (!zxgenwait_n) begin
              state_q <= S_WAIT;
              wcnt_q  <= '0;
            end
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_WAIT: begin
`ifdef ZXBUS_WAIT_EN
          if (!zxgenwait_n) wcnt_q <= wcnt_q + 8'd1;
`endif
        end
        S_HOLD: begin
          if (cnt_q == 4'(T_HOLD - 1)) begin
            state_q       <= S_DONE;
            rsp_valid_q   <= 1'b1;
            zxid_oe_q     <= 1'b0;
            rsp_rdata_q   <= rdata_cap_q;
            rsp_timeout_q <= to_cap_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Strobe release overrides the per-state updates above. Writes and
      // timeouts report 8'hFF, since nothing valid was on the data bus.
      if (exit_ok || exit_to) begin
        state_q     <= S_HOLD;
        cnt_q       <= '0;
        iorq_n_q    <= 1'b1;
        mreq_n_q    <= 1'b1;
        rd_n_q      <= 1'b1;
        wr_n_q      <= 1'b1;
        to_cap_q    <= exit_to;
        rdata_cap_q <= (exit_to || wr_q) ? 8'hFF : zxid_i;
      end
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign zxa         = zxa_q;
  assign zxid_o      = zxid_o_q;
  assign zxid_oe     = zxid_oe_q;
  assign zxiorq_n    = iorq_n_q;
  assign zxmreq_n    = mreq_n_q;
  assign zxrd_n      = rd_n_q;
  assign zxwr_n      = wr_n_q;

endmodule
